mem_responder: RTL and testbench

- Memory-side responder for the multicycle processor's memory interface. It services memRead/memWrite requests from an internal word-addressed RAM.
- Before execution it accepts a program image over a valid/ready load port. It then publishes the start address on loadedAdr and releases the processor from reset.
- Sits beside the processor top level as its sole memory and boot source.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_sp_ram.sv | 26 ++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the memory responder.
// Pure declarations: no latency, no flow control.
package mem_responder_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_ADRBITS = 8;

    typedef enum logic [1:0] {
        LOAD_ADR,
        LOAD_DATA,
        RUN
    } state_t;

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Single-port synchronous RAM: write-enable, registered read, no reset.
// 1-cycle read latency; read data holds until the next read enable; no backpressure.
module sp_ram #(
    parameter int WIDTH   = 16,
    parameter int ADRBITS = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [ADRBITS-1:0] adr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [2**ADRBITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[adr] <= wdata;
        end
        if (re) begin
            rdata <= mem[adr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Boot loader and sole memory for the multicycle processor: loads an image, then serves reads/writes.
// Reads return after 1 cycle; load port is always ready while loading and closed in RUN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADRBITS = DEF_ADRBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic [WIDTH-1:0] adrToMem,
    input  logic [WIDTH-1:0] dataToMem,
    output logic [WIDTH-1:0] dataFromMem,
    output logic [WIDTH-1:0] loadedAdr,
    output logic             cpuReset,
    input  logic             loadValid,
    input  logic [WIDTH-1:0] loadData,
    input  logic             loadLast,
    output logic             loadReady,
    output logic             accessErr
);

    state_t             state;
    logic [ADRBITS-1:0] ptr;
    logic               readSeen;
    logic               loadFire;
    logic               inRun;
    logic               ramWe;
    logic               ramRe;
    logic [ADRBITS-1:0] ramAdr;
    logic [WIDTH-1:0]   ramWdata;
    logic [WIDTH-1:0]   ramRdata;
    logic               unusedAdrBits;

    // Upper address bits alias onto the RAM index and are intentionally dropped.
    assign unusedAdrBits = ^adrToMem[WIDTH-1:ADRBITS];

    assign loadFire = loadValid & loadReady;
    assign inRun    = (state == RUN);
    assign ramWe    = ((state == LOAD_DATA) && loadFire) || (inRun && memWrite);
    assign ramRe    = inRun && memRead && !memWrite;
    assign ramAdr   = inRun ? adrToMem[ADRBITS-1:0] : ptr;
    assign ramWdata = inRun ? dataToMem : loadData;

    // RAM read register has no reset, so gate it until the first real read.
    assign dataFromMem = readSeen ? ramRdata : '0;

    sp_ram #(
        .WIDTH  (WIDTH),
        .ADRBITS(ADRBITS)
    ) uRam (
        .clk  (clk),
        .we   (ramWe),
        .re   (ramRe),
        .adr  (ramAdr),
        .wdata(ramWdata),
        .rdata(ramRdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD_ADR;
            ptr       <= '0;
            loadedAdr <= '0;
            cpuReset  <= 1'b1;
            loadReady <= 1'b0;
            accessErr <= 1'b0;
            readSeen  <= 1'b0;
        end else begin
            case (state)
                LOAD_ADR: begin
                    loadReady <= 1'b1;
                    if (loadFire) begin
                        loadedAdr <= loadData;
                        ptr       <= loadData[ADRBITS-1:0];
                        if (loadLast) begin
                            state     <= RUN;
                            loadReady <= 1'b0;
                        end else begin
                            state <= LOAD_DATA;
                        end
                    end
                end
                LOAD_DATA: begin
                    loadReady <= 1'b1;
                    if (loadFire) begin
                        ptr <= ptr + 1'b1;
                        if (loadLast) begin
                            state     <= RUN;
                            loadReady <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    loadReady <= 1'b0;
                    cpuReset  <= 1'b0;
                    if (memRead && memWrite) begin
                        accessErr <= 1'b1;
                    end
                    if (ramRe) begin
                        readSeen <= 1'b1;
                    end
                end
                default: state <= LOAD_ADR;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: load sequences, processor accesses and resets.
// Read expectations go through a scoreboard queue and are popped when dataFromMem is due.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [15:0] adrToMem = '0;
    logic [15:0] dataToMem = '0;
    logic [15:0] dataFromMem;
    logic [15:0] loadedAdr;
    logic        cpuReset;
    logic        loadValid = 1'b0;
    logic [15:0] loadData = '0;
    logic        loadLast = 1'b0;
    logic        loadReady;
    logic        accessErr;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    logic [15:0] exp;

    mem_responder #(.WIDTH(16), .ADRBITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .adrToMem   (adrToMem),
        .dataToMem  (dataToMem),
        .dataFromMem(dataFromMem),
        .loadedAdr  (loadedAdr),
        .cpuReset   (cpuReset),
        .loadValid  (loadValid),
        .loadData   (loadData),
        .loadLast   (loadLast),
        .loadReady  (loadReady),
        .accessErr  (accessErr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic loadWord(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        loadValid = 1'b1;
        loadData  = d;
        loadLast  = last;
        while (!loadReady && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (loadReady !== 1'b1) begin
            errors++;
            $display("FAIL load_handshake_timeout word=%h: loadReady=%b need 1", d, loadReady);
        end else begin
            step();
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
    endtask

    task automatic issueRead(input logic [15:0] adr, input logic [15:0] expd);
        sb.push_back(expd);
        memRead  = 1'b1;
        adrToMem = adr;
        step();
        memRead  = 1'b0;
    endtask

    task automatic issueWrite(input logic [15:0] adr, input logic [15:0] d);
        memWrite  = 1'b1;
        adrToMem  = adr;
        dataToMem = d;
        step();
        memWrite  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL in_reset_cpuReset got %b need 1", cpuReset); end
        checks++; if (loadReady !== 1'b0) begin errors++; $display("FAIL in_reset_loadReady got %b need 0", loadReady); end
        step();
        reset = 1'b1;
        repeat (5) step();
        checks++; if (loadReady !== 1'b1) begin errors++; $display("FAIL idle_loadReady got %b need 1", loadReady); end
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL idle_cpuReset got %b need 1", cpuReset); end
        checks++; if (dataFromMem !== 16'h0) begin errors++; $display("FAIL idle_dataFromMem got %h need 0000", dataFromMem); end
        checks++; if (loadedAdr !== 16'h0) begin errors++; $display("FAIL idle_loadedAdr got %h need 0000", loadedAdr); end
        checks++; if (accessErr !== 1'b0) begin errors++; $display("FAIL idle_accessErr got %b need 0", accessErr); end
    endtask

    task automatic test_load();
        loadWord(16'h0010, 1'b0);
        loadWord(16'hA001, 1'b0);
        loadWord(16'hB002, 1'b0);
        loadWord(16'hC003, 1'b1);
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL load_cpuReset_at_last got %b need 1", cpuReset); end
        checks++; if (loadReady !== 1'b0) begin errors++; $display("FAIL load_loadReady_closed got %b need 0", loadReady); end
        checks++; if (loadedAdr !== 16'h0010) begin errors++; $display("FAIL load_loadedAdr got %h need 0010", loadedAdr); end
        step();
        checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL load_cpuReset_fall got %b need 0", cpuReset); end
        issueRead(16'h0010, 16'hA001);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL load_ram10 got %h need %h", dataFromMem, exp); end
        issueRead(16'h0012, 16'hC003);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL load_ram12 got %h need %h", dataFromMem, exp); end
    endtask

    task automatic test_run_rw();
        issueRead(16'h0011, 16'hB002);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL run_read11 got %h need %h", dataFromMem, exp); end
        issueWrite(16'h0011, 16'h1234);
        checks++; if (dataFromMem !== 16'hB002) begin errors++; $display("FAIL run_write_hold got %h need b002", dataFromMem); end
        issueRead(16'h0011, 16'h1234);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL run_raw got %h need %h", dataFromMem, exp); end
        step();
        checks++; if (dataFromMem !== 16'h1234) begin errors++; $display("FAIL run_hold got %h need 1234", dataFromMem); end
    endtask

    task automatic test_alias_err();
        issueRead(16'h0111, 16'h1234);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL alias_read got %h need %h", dataFromMem, exp); end
        checks++; if (accessErr !== 1'b0) begin errors++; $display("FAIL err_before got %b need 0", accessErr); end
        memRead = 1'b1;
        issueWrite(16'h0020, 16'h5555);
        memRead = 1'b0;
        checks++; if (accessErr !== 1'b1) begin errors++; $display("FAIL err_set got %b need 1", accessErr); end
        checks++; if (dataFromMem !== 16'h1234) begin errors++; $display("FAIL err_read_suppressed got %h need 1234", dataFromMem); end
        issueRead(16'h0020, 16'h5555);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL err_write_done got %h need %h", dataFromMem, exp); end
        checks++; if (accessErr !== 1'b1) begin errors++; $display("FAIL err_sticky got %b need 1", accessErr); end
    endtask

    task automatic test_ignore_in_load();
        doReset();
        loadWord(16'h0030, 1'b0);
        memRead   = 1'b1;
        memWrite  = 1'b1;
        adrToMem  = 16'h0011;
        dataToMem = 16'hDEAD;
        step();
        memWrite = 1'b0;
        step();
        memRead = 1'b0;
        checks++; if (dataFromMem !== 16'h0) begin errors++; $display("FAIL ignore_dataFromMem got %h need 0000", dataFromMem); end
        checks++; if (accessErr !== 1'b0) begin errors++; $display("FAIL ignore_accessErr got %b need 0", accessErr); end
        loadWord(16'h7777, 1'b1);
        step();
        issueRead(16'h0011, 16'h1234);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL ignore_ram11 got %h need %h", dataFromMem, exp); end
        issueRead(16'h0030, 16'h7777);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL ignore_ram30 got %h need %h", dataFromMem, exp); end
    endtask

    task automatic test_single_word();
        doReset();
        loadWord(16'h0040, 1'b1);
        checks++; if (loadReady !== 1'b0) begin errors++; $display("FAIL single_loadReady got %b need 0", loadReady); end
        checks++; if (loadedAdr !== 16'h0040) begin errors++; $display("FAIL single_loadedAdr got %h need 0040", loadedAdr); end
        step();
        checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL single_cpuReset got %b need 0", cpuReset); end
        issueRead(16'h0020, 16'h5555);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL single_ram_kept got %h need %h", dataFromMem, exp); end
    endtask

    task automatic test_wrap();
        doReset();
        loadWord(16'h12FF, 1'b0);
        loadWord(16'h0AAA, 1'b0);
        loadWord(16'h0BBB, 1'b1);
        step();
        checks++; if (loadedAdr !== 16'h12FF) begin errors++; $display("FAIL wrap_loadedAdr got %h need 12ff", loadedAdr); end
        issueRead(16'h00FF, 16'h0AAA);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL wrap_ramFF got %h need %h", dataFromMem, exp); end
        issueRead(16'h0000, 16'h0BBB);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL wrap_ram00 got %h need %h", dataFromMem, exp); end
    endtask

    task automatic test_reset_mid();
        doReset();
        loadWord(16'h0060, 1'b0);
        loadWord(16'h6666, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (loadedAdr !== 16'h0) begin errors++; $display("FAIL midload_loadedAdr got %h need 0000", loadedAdr); end
        checks++; if (loadReady !== 1'b0) begin errors++; $display("FAIL midload_loadReady got %b need 0", loadReady); end
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL midload_cpuReset got %b need 1", cpuReset); end
        step();
        reset = 1'b1;
        loadWord(16'h0050, 1'b0);
        loadWord(16'h9999, 1'b1);
        step();
        issueRead(16'h0050, 16'h9999);
        exp = sb.pop_front(); checks++; if (dataFromMem !== exp) begin errors++; $display("FAIL reload_ram50 got %h need %h", dataFromMem, exp); end
        memRead = 1'b1;
        issueWrite(16'h0070, 16'h0001);
        memRead = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (dataFromMem !== 16'h0) begin errors++; $display("FAIL midrun_dataFromMem got %h need 0000", dataFromMem); end
        checks++; if (accessErr !== 1'b0) begin errors++; $display("FAIL midrun_accessErr got %b need 0", accessErr); end
        checks++; if (cpuReset !== 1'b1) begin errors++; $display("FAIL midrun_cpuReset got %b need 1", cpuReset); end
        checks++; if (loadedAdr !== 16'h0) begin errors++; $display("FAIL midrun_loadedAdr got %h need 0000", loadedAdr); end
        step();
        reset = 1'b1;
        loadWord(16'h0050, 1'b0);
        loadWord(16'h9999, 1'b1);
        step();
        checks++; if (loadedAdr !== 16'h0050) begin errors++; $display("FAIL reload_loadedAdr got %h need 0050", loadedAdr); end
        checks++; if (cpuReset !== 1'b0) begin errors++; $display("FAIL reload_cpuReset got %b need 0", cpuReset); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_rw();
        test_alias_err();
        test_ignore_in_load();
        test_single_word();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
